// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state type and occupancy encoding for elastic_pipe_reg
//
// Purpose : types and constants shared by the elastic pipeline register and
//           its storage slots.
// Contents: pipe_state_t      - EMPTY / FULL / SKIDDED handshake state
//           OCC_*             - occupancy encodings reported on the occupancy port
//           state_occupancy() - maps a state onto its occupancy encoding

package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FULL    = 2'd1,
    SKIDDED = 2'd2
  } pipe_state_t;

  localparam logic [1:0] OCC_EMPTY   = 2'd0;
  localparam logic [1:0] OCC_FULL    = 2'd1;
  localparam logic [1:0] OCC_SKIDDED = 2'd2;

  function automatic logic [1:0] state_occupancy(input pipe_state_t s);
    case (s)
      FULL:    return OCC_FULL;
      SKIDDED: return OCC_SKIDDED;
      default: return OCC_EMPTY;
    endcase
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - one data+valid storage entry of the elastic pipeline register
//
// Purpose : holds one payload and its valid flag. Used as the main entry and,
//           when skid buffering is enabled, as the skid entry.
// Ports   : clk   - clock; capture edge chosen by NEGEDGE
//           rst   - asynchronous, active-high reset (clears to NOP_VALUE, invalid)
//           load  - capture d and mark valid
//           clear - invalidate and return data to NOP_VALUE (wins over load)
//           d     - payload to capture
//           q     - held payload
//           valid - entry holds a real payload

module pipe_slot #(
  parameter int               WIDTH     = 64,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0,
  parameter bit               NEGEDGE   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             valid
);

  logic cap_clk;

  // A single posedge process serves both edge options; the inversion is
  // resolved at elaboration.
  assign cap_clk = NEGEDGE ? ~clk : clk;

  always_ff @(posedge cap_clk or posedge rst) begin
    if (rst) begin
      q     <= NOP_VALUE;
      valid <= 1'b0;
    end else if (clear) begin
      q     <= NOP_VALUE;
      valid <= 1'b0;
    end else if (load) begin
      q     <= d;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/elastic_pipe_reg.sv
// rtl/elastic_pipe_reg.sv - handshaked pipeline register with optional skid entry and flush
//
// Purpose : valid/ready pipeline register between two core stages. Flush
//           inserts a NOP bubble; with SKID=1 in_ready is a register so
//           downstream stalls do not ripple combinationally upstream.
// Ports   : clk         - clock; capture edge chosen by NEGEDGE
//           rst         - asynchronous, active-high reset
//           flush       - drop all held entries, ignore a same-edge input
//           in_valid    - upstream offers in_data
//           in_ready    - block accepts on this edge
//           in_data     - upstream payload
//           out_valid   - out_data is a real payload
//           out_ready   - downstream consumes on this edge
//           out_data    - payload, or NOP_VALUE when out_valid is low
//           occupancy   - entries held (0..2)
//           flush_drops - saturating count of entries discarded by flush

module elastic_pipe_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 64,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0,
  parameter bit               SKID      = 1'b1,
  parameter bit               NEGEDGE   = 1'b1,
  parameter int               DROP_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [1:0]        occupancy,
  output logic [DROP_W-1:0] flush_drops
);

  pipe_state_t       state;
  pipe_state_t       state_next;
  logic              cap_clk;
  logic              main_load;
  logic              main_clear;
  logic [WIDTH-1:0]  main_d;
  logic [WIDTH-1:0]  main_q;
  logic              main_valid;
  logic [WIDTH-1:0]  skid_q;
  logic              skid_valid;
  logic [DROP_W-1:0] drop_cnt;
  logic [1:0]        held;
  logic [DROP_W:0]   drop_sum;

  assign cap_clk = NEGEDGE ? ~clk : clk;

  always_ff @(posedge cap_clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Every branch that loads from in_data is one in which in_ready is high,
  // so in_valid alone qualifies the accept here.
  always_comb begin
    state_next = state;
    main_load  = 1'b0;
    main_clear = 1'b0;
    if (flush) begin
      state_next = EMPTY;
      main_clear = 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (in_valid) begin
            main_load  = 1'b1;
            state_next = FULL;
          end
        end
        FULL: begin
          if (out_ready) begin
            if (in_valid) begin
              main_load = 1'b1;
            end else begin
              main_clear = 1'b1;
              state_next = EMPTY;
            end
          end else if (SKID && in_valid) begin
            state_next = SKIDDED;
          end
        end
        SKIDDED: begin
          if (out_ready) begin
            main_load  = 1'b1;
            state_next = FULL;
          end
        end
        default: begin
          state_next = EMPTY;
          main_clear = 1'b1;
        end
      endcase
    end
  end

  // Leaving SKIDDED promotes the skid entry into main instead of taking input.
  assign main_d = (state == SKIDDED) ? skid_q : in_data;

  pipe_slot #(
    .WIDTH     (WIDTH),
    .NOP_VALUE (NOP_VALUE),
    .NEGEDGE   (NEGEDGE)
  ) u_main (
    .clk   (clk),
    .rst   (rst),
    .load  (main_load),
    .clear (main_clear),
    .d     (main_d),
    .q     (main_q),
    .valid (main_valid)
  );

  generate
    if (SKID) begin : g_skid
      logic skid_load;
      logic skid_clear;
      logic in_ready_q;

      assign skid_load  = (state == FULL) && (state_next == SKIDDED);
      assign skid_clear = flush || ((state == SKIDDED) && (state_next == FULL));

      pipe_slot #(
        .WIDTH     (WIDTH),
        .NOP_VALUE (NOP_VALUE),
        .NEGEDGE   (NEGEDGE)
      ) u_skid (
        .clk   (clk),
        .rst   (rst),
        .load  (skid_load),
        .clear (skid_clear),
        .d     (in_data),
        .q     (skid_q),
        .valid (skid_valid)
      );

      // Registered ready: only SKIDDED refuses input, so a one-edge stall is
      // absorbed by the skid entry and ready drops one edge later.
      always_ff @(posedge cap_clk or posedge rst) begin
        if (rst) begin
          in_ready_q <= 1'b1;
        end else begin
          in_ready_q <= (state_next != SKIDDED);
        end
      end

      assign in_ready = in_ready_q;
    end else begin : g_no_skid
      assign skid_q     = NOP_VALUE;
      assign skid_valid = 1'b0;
      assign in_ready   = !main_valid || out_ready;
    end
  endgenerate

  // Entries lost to a flush are exactly the valid slots held before the edge.
  assign held     = {1'b0, main_valid} + {1'b0, skid_valid};
  assign drop_sum = {1'b0, drop_cnt} + (DROP_W + 1)'(held);

  always_ff @(posedge cap_clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (flush) begin
      drop_cnt <= drop_sum[DROP_W] ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
    end
  end

  assign out_valid   = main_valid;
  assign out_data    = main_valid ? main_q : NOP_VALUE;
  assign occupancy   = state_occupancy(state);
  assign flush_drops = drop_cnt;

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// tb/tb_elastic_pipe_reg.sv - self-checking bench for elastic_pipe_reg against a queue model

module tb_elastic_pipe_reg;

  localparam logic [15:0] NOP     = 16'h0013;
  localparam logic [27:0] RST_VEC = {1'b1, 1'b0, NOP, 2'd0, 8'd0};

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_ready;

  logic        ir_a, ov_a, ir_b, ov_b, ir_c, ov_c;
  logic [15:0] od_a, od_b, od_c;
  logic [1:0]  oc_a, oc_b, oc_c;
  logic [7:0]  fd_a, fd_b;
  logic [1:0]  fd_c;

  int checks = 0;
  int errors = 0;

  // Reference model: per instance, an ordered list of held payloads plus a drop count.
  int          cnt   [3];
  logic [15:0] ent   [3][2];
  int          drops [3];

  // dut_a: skid, falling edge. dut_b: no skid, rising edge. dut_c: skid, rising edge, 2-bit drops.
  elastic_pipe_reg #(.WIDTH(16), .NOP_VALUE(NOP), .SKID(1'b1), .NEGEDGE(1'b1), .DROP_W(8)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir_a), .in_data(in_data),
    .out_valid(ov_a), .out_ready(out_ready), .out_data(od_a), .occupancy(oc_a), .flush_drops(fd_a));

  elastic_pipe_reg #(.WIDTH(16), .NOP_VALUE(NOP), .SKID(1'b0), .NEGEDGE(1'b0), .DROP_W(8)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir_b), .in_data(in_data),
    .out_valid(ov_b), .out_ready(out_ready), .out_data(od_b), .occupancy(oc_b), .flush_drops(fd_b));

  elastic_pipe_reg #(.WIDTH(16), .NOP_VALUE(NOP), .SKID(1'b1), .NEGEDGE(1'b0), .DROP_W(2)) dut_c (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir_c), .in_data(in_data),
    .out_valid(ov_c), .out_ready(out_ready), .out_data(od_c), .occupancy(oc_c), .flush_drops(fd_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit is_skid(input int k);
    return k != 1;
  endfunction

  function automatic int dmax(input int k);
    return (k == 2) ? 3 : 255;
  endfunction

  function automatic bit model_rdy(input int k);
    if (is_skid(k)) return cnt[k] < 2;
    return (cnt[k] == 0) || out_ready;
  endfunction

  function automatic logic [27:0] exp_vec(input int k);
    logic        rdy;
    logic [15:0] d;
    rdy = model_rdy(k);
    d   = (cnt[k] > 0) ? ent[k][0] : NOP;
    return {rdy, cnt[k] > 0, d, 2'(cnt[k]), 8'(drops[k])};
  endfunction

  function automatic logic [27:0] obs_vec(input int k);
    case (k)
      0:       return {ir_a, ov_a, od_a, oc_a, fd_a};
      1:       return {ir_b, ov_b, od_b, oc_b, fd_b};
      default: return {ir_c, ov_c, od_c, oc_c, 6'd0, fd_c};
    endcase
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      cnt[k]   = 0;
      drops[k] = 0;
    end
  endtask

  task automatic model_edge(input int k);
    bit acc;
    if (rst) return;
    if (flush) begin
      drops[k] = (drops[k] + cnt[k] > dmax(k)) ? dmax(k) : drops[k] + cnt[k];
      cnt[k]   = 0;
    end else begin
      acc = in_valid && model_rdy(k);
      if (cnt[k] > 0 && out_ready) begin
        ent[k][0] = ent[k][1];
        cnt[k]--;
      end
      if (acc) begin
        ent[k][cnt[k]] = in_data;
        cnt[k]++;
      end
    end
  endtask

  // Called at rising edge + 1; dut_a captures at the following falling edge.
  task automatic drive(input logic fl, input logic iv, input logic [15:0] d, input logic ordy);
    flush     = fl;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    model_edge(0);
    #6;
  endtask

  // Returns at rising edge + 7: dut_a has seen these inputs, dut_b/dut_c see them next rising edge.
  task automatic step(input logic fl, input logic iv, input logic [15:0] d, input logic ordy);
    @(posedge clk);
    model_edge(1);
    model_edge(2);
    #1;
    drive(fl, iv, d, ordy);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs_vec(k) !== RST_VEC) begin
        errors++;
        $display("FAIL reset dut%0d: got %h want %h", k, obs_vec(k), RST_VEC);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_stream();
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b1, 16'(i), 1'b1);
      checks++;
      if (od_a !== 16'(i) || ir_a !== 1'b1 || oc_a !== 2'd1) begin
        errors++;
        $display("FAIL stream_a step%0d: data=%h ready=%b occ=%0d want %h 1 1", i, od_a, ir_a, oc_a, 16'(i));
      end
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs_vec(k) !== exp_vec(k)) begin
          errors++;
          $display("FAIL stream dut%0d step%0d: got %h want %h", k, i, obs_vec(k), exp_vec(k));
        end
      end
    end
    step(1'b0, 1'b0, 16'h0, 1'b1);
    step(1'b0, 1'b0, 16'h0, 1'b1);
  endtask

  task automatic test_edge_select();
    do_reset();
    step(1'b0, 1'b1, 16'h0099, 1'b0);
    checks++;
    if (ov_a !== 1'b1 || od_a !== 16'h0099) begin
      errors++;
      $display("FAIL edge_neg: valid=%b data=%h want 1 0099", ov_a, od_a);
    end
    checks++;
    if (ov_b !== 1'b0 || ov_c !== 1'b0) begin
      errors++;
      $display("FAIL edge_pos_early: valid_b=%b valid_c=%b want 0 0", ov_b, ov_c);
    end
    step(1'b0, 1'b0, 16'h0, 1'b0);
    checks++;
    if (ov_b !== 1'b1 || od_b !== 16'h0099 || ov_c !== 1'b1 || od_c !== 16'h0099) begin
      errors++;
      $display("FAIL edge_pos: b=%b/%h c=%b/%h want 1/0099", ov_b, od_b, ov_c, od_c);
    end
  endtask

  task automatic test_stall();
    logic        t_iv  [6];
    logic [15:0] t_d   [6];
    logic        t_or  [6];
    logic [15:0] t_od  [6];
    logic [1:0]  t_occ [6];
    logic        t_ir  [6];
    t_iv  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    t_d   = '{16'h000A, 16'h000B, 16'h000C, 16'h000C, 16'h000C, 16'h0000};
    t_or  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    t_od  = '{16'h000A, 16'h000A, 16'h000A, 16'h000B, 16'h000C, NOP};
    t_occ = '{2'd1, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0};
    t_ir  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b0, t_iv[i], t_d[i], t_or[i]);
      checks++;
      if (od_a !== t_od[i] || oc_a !== t_occ[i] || ir_a !== t_ir[i]) begin
        errors++;
        $display("FAIL stall_a step%0d: data=%h occ=%0d ready=%b want %h %0d %b",
                 i, od_a, oc_a, ir_a, t_od[i], t_occ[i], t_ir[i]);
      end
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs_vec(k) !== exp_vec(k)) begin
          errors++;
          $display("FAIL stall dut%0d step%0d: got %h want %h", k, i, obs_vec(k), exp_vec(k));
        end
      end
    end
  endtask

  task automatic test_flush();
    do_reset();
    step(1'b0, 1'b1, 16'h000A, 1'b1);
    step(1'b0, 1'b1, 16'h000B, 1'b0);
    step(1'b1, 1'b1, 16'h000D, 1'b0);
    checks++;
    if (ov_a !== 1'b0 || od_a !== NOP || fd_a !== 8'd2 || oc_a !== 2'd0 || ir_a !== 1'b1) begin
      errors++;
      $display("FAIL flush_a: valid=%b data=%h drops=%0d occ=%0d ready=%b want 0 %h 2 0 1",
               ov_a, od_a, fd_a, oc_a, ir_a, NOP);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 16'h0, 1'b1);
      checks++;
      if (ov_a !== 1'b0 || ov_c !== 1'b0 || od_a === 16'h000D || od_c === 16'h000D) begin
        errors++;
        $display("FAIL flush_bubble step%0d: a=%b/%h c=%b/%h want 0/%h", i, ov_a, od_a, ov_c, od_c, NOP);
      end
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs_vec(k) !== exp_vec(k)) begin
          errors++;
          $display("FAIL flush dut%0d step%0d: got %h want %h", k, i, obs_vec(k), exp_vec(k));
        end
      end
    end
    checks++;
    if (fd_c !== 2'd2) begin
      errors++;
      $display("FAIL flush_c_drops: got %0d want 2", fd_c);
    end
  endtask

  task automatic test_skid0();
    logic [15:0] e;
    do_reset();
    step(1'b0, 1'b1, 16'h0055, 1'b1);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    checks++;
    if (ov_b !== 1'b1 || ir_b !== 1'b0) begin
      errors++;
      $display("FAIL skid0_stall: valid=%b ready=%b want 1 0", ov_b, ir_b);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (ir_b !== 1'b1) begin
      errors++;
      $display("FAIL skid0_comb_ready: got %b want 1", ir_b);
    end
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 16'h0060 + 16'(i), 1'b1);
      if (i >= 1) begin
        e = 16'h0060 + 16'(i - 1);
        checks++;
        if (od_b !== e || ir_b !== 1'b1 || oc_b !== 2'd1) begin
          errors++;
          $display("FAIL skid0_rate step%0d: data=%h ready=%b occ=%0d want %h 1 1", i, od_b, ir_b, oc_b, e);
        end
      end
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs_vec(k) !== exp_vec(k)) begin
          errors++;
          $display("FAIL skid0 dut%0d step%0d: got %h want %h", k, i, obs_vec(k), exp_vec(k));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(1'b0, 1'b1, 16'h0007, 1'b0);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    for (int i = 1; i <= 3; i++) step(1'b0, 1'b1, 16'h0040 + 16'(i), 1'b0);
    #1;
    rst       = 1'b1;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    model_clear();
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs_vec(k) !== RST_VEC) begin
        errors++;
        $display("FAIL reset_mid dut%0d: got %h want %h", k, obs_vec(k), RST_VEC);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b0, 1'b1, 16'h0077, 1'b1);
    checks++;
    if (ov_a !== 1'b1 || od_a !== 16'h0077) begin
      errors++;
      $display("FAIL reset_release: valid=%b data=%h want 1 0077", ov_a, od_a);
    end
    step(1'b0, 1'b0, 16'h0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs_vec(k) !== exp_vec(k)) begin
        errors++;
        $display("FAIL reset_release dut%0d: got %h want %h", k, obs_vec(k), exp_vec(k));
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int f = 0; f < 5; f++) begin
      step(1'b0, 1'b1, 16'h0030 + 16'(f), 1'b0);
      step(1'b1, 1'b0, 16'h0, 1'b0);
      if (f == 2) begin
        checks++;
        if (fd_c !== 2'd2) begin
          errors++;
          $display("FAIL sat_mid: got %0d want 2", fd_c);
        end
      end
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs_vec(k) !== exp_vec(k)) begin
          errors++;
          $display("FAIL sat dut%0d flush%0d: got %h want %h", k, f, obs_vec(k), exp_vec(k));
        end
      end
    end
    step(1'b0, 1'b0, 16'h0, 1'b0);
    checks++;
    if (fd_c !== 2'd3 || fd_a !== 8'd5 || fd_b !== 8'd5) begin
      errors++;
      $display("FAIL sat_final: c=%0d a=%0d b=%0d want 3 5 5", fd_c, fd_a, fd_b);
    end
  endtask

  task automatic test_random();
    logic        fl, iv, ordy;
    logic [15:0] d;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      fl   = ($urandom % 16) == 0;
      iv   = ($urandom % 4) != 0;
      ordy = ($urandom % 3) != 0;
      d    = 16'($urandom);
      step(fl, iv, d, ordy);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs_vec(k) !== exp_vec(k)) begin
          errors++;
          $display("FAIL random dut%0d step%0d: got %h want %h", k, n, obs_vec(k), exp_vec(k));
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks so far", checks);
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_stream();
    test_edge_select();
    test_stall();
    test_flush();
    test_skid0();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/elastic_pipe_reg.md
# elastic_pipe_reg

Parametrised, handshaked pipeline register that replaces the fixed IF/ID-style latch between any two stages of the pipelined core. Payload width, NOP value, capture edge and buffering depth are set by parameters. Stall is expressed with valid/ready backpressure instead of a write-enable, and flush inserts a NOP bubble. With the skid option enabled, `in_ready` is fully registered, which breaks the combinational stall path from downstream hazards back to the upstream stage.

## Interface

**Parameters**
- `WIDTH`, 64 — payload bits (e.g. {pc, instr}).
- `NOP_VALUE`, '0 — value driven on `out_data` whenever `out_valid`=0.
- `SKID`, 1 — 1: two-entry skid buffer with registered `in_ready`. 0: single entry with combinational `in_ready`.
- `NEGEDGE`, 1 — 1: all state captured on falling `clk`. 0: on rising `clk`.
- `DROP_W`, 8 — width of the flush-drop counter.

**Ports**
- `clk` in 1 — clock; capture edge is selected by `NEGEDGE`.
- `rst` in 1 — reset, asynchronous, active-high.
- `flush` in 1 — discard all held entries and insert a bubble.
- `in_valid` in 1 — upstream has a payload.
- `in_ready` out 1 — block accepts a payload on this edge.
- `in_data` in WIDTH — upstream payload.
- `out_valid` out 1 — `out_data` holds a real payload.
- `out_ready` in 1 — downstream consumes on this edge (0 = stall).
- `out_data` out WIDTH — downstream payload.
- `occupancy` out 2 — number of valid entries held (0..2).
- `flush_drops` out DROP_W — saturating count of valid entries discarded by flush.

## Operation

- **Handshake.**
  - A transfer in occurs when `in_valid`&&`in_ready` at a capture edge; a transfer out occurs when `out_valid`&&`out_ready`.
  - Payloads leave in arrival order, none duplicated, none lost except by flush.
- **State machine** (type `pipe_state_t`):
  - EMPTY: `out_valid`=0, `in_ready`=1.
    - `in_valid` → main←`in_data`, go to FULL.
  - FULL: `out_valid`=1.
    - `out_ready`&&`in_valid` → main←`in_data`, stay FULL.
    - `out_ready`&&!`in_valid` → EMPTY.
    - !`out_ready`&&`in_valid` (SKID=1 only) → skid←`in_data`, go to SKIDDED.
    - !`out_ready`&&!`in_valid` → hold.
  - SKIDDED: `in_ready`=0, `out_valid`=1, out = main.
    - `out_ready` → main←skid, go to FULL.
    - Otherwise hold.
- **SKID=0.** SKIDDED is unreachable and `in_ready` = !`out_valid` || `out_ready` (combinational).
- **SKID=1.** `in_ready` is a register equal to (next state != SKIDDED).
- **Flush.**
  - Priority is below `rst` and above everything else.
  - Next state is EMPTY and both entries are invalidated.
  - A same-edge `in_valid` payload is discarded: `in_ready` may read 1 combinationally, but nothing is captured.
  - `flush_drops` += number of valid entries held before the edge (0, 1 or 2), saturating at 2^DROP_W−1.
- **Data output.**
  - `out_data` = main when `out_valid`, else `NOP_VALUE`.
  - A flushed or empty stage therefore always presents a NOP downstream.
- **Occupancy.** `occupancy` = 0/1/2 for EMPTY/FULL/SKIDDED.
- **Reset values.**
  - State EMPTY, `out_valid`=0, `in_ready`=1, `out_data`=`NOP_VALUE`, `occupancy`=0, `flush_drops`=0.
  - Main and skid storage are cleared to `NOP_VALUE`.

## Timing

- **Latency.** 1 capture edge from accept to `out_valid`. Throughput is 1 payload per edge when `out_ready` stays high.
- **Update timing.** All outputs change only on the capture edge, or immediately on `rst` assertion. `in_ready` with SKID=0 is the only combinational output.
- **One-cycle stall.** Under a stall of exactly one edge with continuous input, SKID=1 absorbs the extra payload without dropping `in_ready` for that edge. `in_ready` falls on the following edge.
- **Release from SKIDDED.** `in_ready` returns to 1 on the same edge that main←skid.
- **Reset mid-operation.** Held entries vanish with no drop count and no output transfer. Release is synchronous to the capture edge, and the first accept is possible on the first edge after deassertion.
- **Saturation.** `flush_drops` holds at all-ones; it does not wrap.

## Structure

- **Package `pipe_pkg`** holds:
  - the typedef `pipe_state_t` {EMPTY, FULL, SKIDDED};
  - the occupancy encoding constants.
- **Sub-module `pipe_slot`** (WIDTH, NOP_VALUE, NEGEDGE): a data+valid register with load, clear and async reset. It is instantiated twice, as main and skid; the skid instance is generated only when SKID=1.
- **Top level** holds the state machine, the `in_ready` register, output muxing and the drop counter.

## Test plan

- **Reset.** Reset, then stream payloads 0x1..0x8 with `out_ready`=1 → `out_data` follows one edge later, `in_ready` stays 1, `occupancy` stays 1.
- **Stall.** SKID=1 with 0xA, 0xB, 0xC sent back-to-back and `out_ready`=0 from the second edge → `occupancy`=2 and `in_ready`=0 after 0xB. 0xC is held upstream. Releasing `out_ready` gives A, B, C in order with no duplicates.
- **Flush.** Flush while SKIDDED with `in_valid`=1 carrying 0xD → next edge `out_valid`=0, `out_data`=`NOP_VALUE`, `flush_drops`=2, and 0xD never appears.
- **SKID=0.** `out_ready`=0 while FULL → `in_ready`=0 in the same cycle. `out_ready`=1 with `in_valid`=1 → pass-through at full rate.
- **Reset mid-stream and saturation.**
  - Assert `rst` mid-stream between edges → outputs reach their reset values immediately.
  - With DROP_W=2, apply 5 flushes over a full stage → `flush_drops` saturates at 3.
- **Edge selection.** NEGEDGE=0 vs 1 → capture occurs on the selected edge only; the checker samples on the opposite edge.
